ram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port testbench RAM between two requesters: port 0 is instruction fetch and port 1 is load/store. Each requester sees a req/gnt command handshake and an rvalid completion pulse. The block drives the RAM control and address pins for exactly one cycle per transaction and registers the RAM read data for the winning port. It sits between the core's memory ports and the RAM in the SoC testbench.

---
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Two-port round-robin arbiter in front of a single-port RAM.
//            Port 0 = instruction fetch, port 1 = load/store. Each accepted
//            command occupies one ACCESS cycle (gnt + RAM pins) followed by
//            one RESP cycle (rvalid + registered read data).
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DWIDTH-1:0] p0_rdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DWIDTH-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [31:0]       addr,
    output logic [DWIDTH-1:0] data_wr,
    input  logic [DWIDTH-1:0] data_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t r_state;
    logic   r_port;     // port owning the current transaction
    logic   r_last;     // port served most recently (tie-break pointer)

    logic              w_any;
    logic              w_win;
    logic              w_we;
    logic [31:0]       w_addr;
    logic [DWIDTH-1:0] w_wdata;

    // Round-robin winner: a lone requester wins; on a tie the port not served last wins
    assign w_any   = p0_req | p1_req;
    assign w_win   = (p0_req & p1_req) ? ~r_last : p1_req;
    assign w_we    = w_win ? p1_we    : p0_we;
    assign w_addr  = w_win ? p1_addr  : p0_addr;
    assign w_wdata = w_win ? p1_wdata : p0_wdata;

    // Arbitration FSM; the RAM pins double as the latched command register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_port    <= 1'b0;
            r_last    <= 1'b1;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            addr      <= '0;
            data_wr   <= '0;
        end else begin
            // Pulses and RAM pins are low unless this edge opens an ACCESS or RESP
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            addr      <= '0;
            data_wr   <= '0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_any) begin
                        r_state <= S_ACCESS;
                        r_port  <= w_win;
                        mem_en  <= 1'b1;
                        mem_wr  <= w_we;
                        addr    <= w_addr;
                        data_wr <= w_wdata;
                        p0_gnt  <= ~w_win;
                        p1_gnt  <= w_win;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_state   <= S_RESP;
                    r_last    <= r_port;
                    p0_rvalid <= ~r_port;
                    p1_rvalid <= r_port;
                    // Reads capture RAM data; writes leave rdata untouched
                    if (!mem_wr) begin
                        if (r_port) begin
                            p1_rdata <= data_rd;
                        end else begin
                            p0_rdata <= data_rd;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Self-checking bench for ram_arbiter. A transaction-level model
//            predicts grants, completions and read data cycle by cycle from
//            the arbitration rules; directed scenarios are followed by a
//            randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int DWIDTH = 32;

    logic              clk;
    logic              rstn;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [31:0]       ad [2];
    logic [DWIDTH-1:0] wd [2];
    logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DWIDTH-1:0] p0_rdata, p1_rdata;
    logic              mem_en, mem_wr;
    logic [31:0]       addr;
    logic [DWIDTH-1:0] data_wr, data_rd;

    ram_arbiter #(.DWIDTH(DWIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .p0_req    (req[0]),
        .p0_we     (we[0]),
        .p0_addr   (ad[0]),
        .p0_wdata  (wd[0]),
        .p1_req    (req[1]),
        .p1_we     (we[1]),
        .p1_addr   (ad[1]),
        .p1_wdata  (wd[1]),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .addr      (addr),
        .data_wr   (data_wr),
        .data_rd   (data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: combinational read, write on the rising edge
    logic [DWIDTH-1:0] ram [16];
    assign data_rd = mem_en ? ram[addr[3:0]] : '0;
    always @(posedge clk) begin
        if (mem_en && mem_wr) ram[addr[3:0]] <= data_wr;
    end

    // Reference model state
    logic [DWIDTH-1:0] ref_mem [16];
    logic [DWIDTH-1:0] e_rdata [2];
    logic              acc;       // a transaction is on the RAM pins this cycle
    logic              resp_now;  // a completion is due this cycle
    logic              gp, rp, last;
    logic              cwe;
    logic [31:0]       caddr;
    logic [DWIDTH-1:0] cwd;
    logic [1:0]        renew;     // on gnt, issue a fresh command instead of dropping req

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("p0_gnt",    p0_gnt,    acc && !gp);
        chk("p1_gnt",    p1_gnt,    acc && gp);
        chk("p0_rvalid", p0_rvalid, resp_now && !rp);
        chk("p1_rvalid", p1_rvalid, resp_now && rp);
        chk("p0_rdata",  p0_rdata,  e_rdata[0]);
        chk("p1_rdata",  p1_rdata,  e_rdata[1]);
        chk("mem_en",    mem_en,    acc);
        chk("mem_wr",    mem_wr,    acc ? cwe : 1'b0);
        chk("addr",      addr,      acc ? caddr : 32'd0);
        chk("data_wr",   data_wr,   acc ? cwd : '0);
    endtask

    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [DWIDTH-1:0] d);
        req[p] = 1'b1;
        we[p]  = w;
        ad[p]  = a;
        wd[p]  = d;
    endtask

    task automatic new_cmd(input int p);
        issue(p, 1'(($urandom_range(0, 1))), 32'($urandom_range(0, 15)), DWIDTH'($urandom));
    endtask

    // One clock: advance the model on the edge, compare, then react to grants
    task automatic step();
        @(posedge clk);
        resp_now = 1'b0;
        if (acc) begin
            // The cycle after a grant is always its completion, never a new grant
            resp_now = 1'b1;
            rp       = gp;
            if (cwe) ref_mem[caddr[3:0]] = cwd;
            else     e_rdata[gp] = ref_mem[caddr[3:0]];
            last = gp;
            acc  = 1'b0;
        end else if (req[0] || req[1]) begin
            gp    = (req[0] && req[1]) ? ~last : req[1];
            cwe   = we[gp];
            caddr = ad[gp];
            cwd   = wd[gp];
            acc   = 1'b1;
        end
        #1;
        check_all();
        for (int p = 0; p < 2; p++) begin
            if (acc && (gp == p[0])) begin
                if (renew[p]) new_cmd(p);
                else          req[p] = 1'b0;
            end
        end
    endtask

    // Asynchronous reset in the middle of the current cycle
    task automatic reset_mid();
        #2;
        rstn     = 1'b0;
        req      = '0;
        acc      = 1'b0;
        resp_now = 1'b0;
        last     = 1'b1;
        e_rdata[0] = '0;
        e_rdata[1] = '0;
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        req  = '0;
        we   = '0;
        ad[0] = '0; ad[1] = '0;
        wd[0] = '0; wd[1] = '0;
        renew = '0;
        acc = 1'b0; resp_now = 1'b0; gp = 1'b0; rp = 1'b0; last = 1'b1;
        cwe = 1'b0; caddr = '0; cwd = '0;
        e_rdata[0] = '0; e_rdata[1] = '0;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;

        // Reset mid-ACCESS discards the write; addr 4 then reads 0
        issue(0, 1'b1, 32'd4, 32'hA5A5_A5A5);
        step();
        reset_mid();
        step();
        issue(0, 1'b0, 32'd4, '0);
        repeat (3) step();

        // Single write then read on port 0
        issue(0, 1'b1, 32'd8, 32'h1234_5678);
        repeat (2) step();
        issue(0, 1'b0, 32'd8, '0);
        repeat (4) step();

        // Tie out of reset: port 0 first, then port 1
        reset_mid();
        issue(0, 1'b0, 32'd8, '0);
        issue(1, 1'b0, 32'd8, '0);
        repeat (6) step();

        // Sustained contention: 8 transactions alternating 0,1,0,1...
        renew = 2'b11;
        new_cmd(0);
        new_cmd(1);
        repeat (16) step();
        renew = 2'b00;
        repeat (4) step();

        // Back-to-back regrant of port 1 directly from RESP
        issue(1, 1'b1, 32'd9, 32'hCAFE_0009);
        renew[1] = 1'b1;
        repeat (3) step();
        renew[1] = 1'b0;
        issue(1, 1'b0, 32'd9, '0);
        repeat (4) step();

        // Withdrawal: port 1 requests for one cycle during port 0's ACCESS
        issue(0, 1'b0, 32'd3, '0);
        step();
        issue(1, 1'b0, 32'd5, '0);
        step();
        req[1] = 1'b0;
        repeat (3) step();

        // Randomized traffic with occasional withdrawals
        for (int c = 0; c < 400; c++) begin
            renew = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                if (!req[p]) begin
                    if ($urandom_range(0, 2) == 0) new_cmd(p);
                end else if (!(acc && (gp == p[0])) && ($urandom_range(0, 15) == 0)) begin
                    req[p] = 1'b0;
                end
            end
            step();
        end
        renew = 2'b00;
        req   = '0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
